// File: rtl/pc_unit.sv
// pc_unit: program-counter unit at the head of the IF stage.
//
// Holds the fetch PC and picks the next PC by fixed priority:
//   trap entry > misaligned redirect (treated as a trap) > trap return
//   > aligned redirect > sequential increment > stall (hold).
// A BOOT/RUN/HALT controller gates fetch for debug halting, and a
// saturating counter records RUN cycles spent stalled.
//
// Handshake note: this block has no valid/ready pairs. Every request input
// (trap_valid, redirect_valid, mret_valid, halt_req, resume) is a
// single-cycle level sampled on the rising clk edge. It is consumed on that
// edge with no back-pressure. flush is combinational in the request cycle,
// so IF/ID can squash the wrong-path instruction it would latch on that edge.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   pc_write        1 = IF may advance, 0 = stall
//   redirect_valid  taken branch/jump from EX, target in redirect_pc
//   trap_valid      exception/ecall, faulting address in trap_epc
//   mret_valid      trap return to mepc
//   halt_req        debug halt request
//   resume          debug resume
//   pc              current fetch PC
//   if_valid        pc is a valid fetch this cycle (state == RUN)
//   flush           squash the IF/ID instruction (wrong path)
//   mepc            captured trap return address
//   misalign        sticky flag: a misaligned redirect has occurred
//   halted          state == HALT
//   stall_cnt       saturating count of RUN cycles with pc_write = 0
//   state_dbg       raw controller state (BOOT=0, RUN=1, HALT=2)
module pc_unit #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(32'h0000_1000),
  parameter int              IALIGN    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_epc,
  input  logic             mret_valid,
  input  logic             halt_req,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic             if_valid,
  output logic             flush,
  output logic [WIDTH-1:0] mepc,
  output logic             misalign,
  output logic             halted,
  output logic [WIDTH-1:0] stall_cnt,
  output logic [1:0]       state_dbg
);

  localparam int              ALIGN_BITS = $clog2(IALIGN);
  localparam logic [WIDTH-1:0] STEP       = WIDTH'(IALIGN);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] pc_d, mepc_d, stall_cnt_d;
  logic             misalign_d;
  logic             redirect_misaligned;

  // Low address bits of the target must be zero for a legal instruction fetch.
  assign redirect_misaligned = |redirect_pc[ALIGN_BITS-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      pc        <= RESET_VEC;
      mepc      <= '0;
      misalign  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      mepc      <= mepc_d;
      misalign  <= misalign_d;
      stall_cnt <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state;
    pc_d        = pc;
    mepc_d      = mepc;
    misalign_d  = misalign;
    stall_cnt_d = stall_cnt;
    flush       = 1'b0;

    unique case (state)
      BOOT: begin
        // One dead cycle after reset so the first valid fetch is RESET_VEC.
        state_d = RUN;
      end

      RUN: begin
        flush = trap_valid | redirect_valid | mret_valid;

        if (trap_valid) begin
          pc_d   = TRAP_VEC;
          mepc_d = trap_epc;
        end else if (redirect_valid && redirect_misaligned) begin
          pc_d       = TRAP_VEC;
          mepc_d     = redirect_pc;
          misalign_d = 1'b1;
        end else if (mret_valid) begin
          pc_d = mepc;
        end else if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (pc_write) begin
          pc_d = pc + STEP;
        end else if (stall_cnt != '1) begin
          stall_cnt_d = stall_cnt + WIDTH'(1);
        end

        // The PC update above still happens on the edge that enters HALT.
        if (halt_req) begin
          state_d = HALT;
        end
      end

      HALT: begin
        // resume has priority over a simultaneous halt_req.
        if (resume) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign if_valid  = (state == RUN);
  assign halted    = (state == HALT);
  assign state_dbg = state;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit instance for the main scenarios and
// an 8-bit instance for wrap-around and stall-counter saturation.
module tb_pc_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- 32-bit DUT ----------------
  logic        rst, pc_write, redirect_valid, trap_valid, mret_valid, halt_req, resume;
  logic [31:0] redirect_pc, trap_epc;
  logic [31:0] pc, mepc, stall_cnt;
  logic        if_valid, flush, misalign, halted;
  logic [1:0]  state_dbg;

  pc_unit u_dut (
    .clk(clk), .rst(rst), .pc_write(pc_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_epc(trap_epc), .mret_valid(mret_valid),
    .halt_req(halt_req), .resume(resume),
    .pc(pc), .if_valid(if_valid), .flush(flush), .mepc(mepc),
    .misalign(misalign), .halted(halted), .stall_cnt(stall_cnt),
    .state_dbg(state_dbg)
  );

  // ---------------- 8-bit DUT ----------------
  logic       rst8, pc_write8, redirect_valid8, trap_valid8, mret_valid8, halt_req8, resume8;
  logic [7:0] redirect_pc8, trap_epc8;
  logic [7:0] pc8, mepc8, stall_cnt8;
  logic       if_valid8, flush8, misalign8, halted8;
  logic [1:0] state_dbg8;

  pc_unit #(.WIDTH(8), .RESET_VEC(8'hF8), .TRAP_VEC(8'h80), .IALIGN(4)) u_dut8 (
    .clk(clk), .rst(rst8), .pc_write(pc_write8),
    .redirect_valid(redirect_valid8), .redirect_pc(redirect_pc8),
    .trap_valid(trap_valid8), .trap_epc(trap_epc8), .mret_valid(mret_valid8),
    .halt_req(halt_req8), .resume(resume8),
    .pc(pc8), .if_valid(if_valid8), .flush(flush8), .mepc(mepc8),
    .misalign(misalign8), .halted(halted8), .stall_cnt(stall_cnt8),
    .state_dbg(state_dbg8)
  );

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    redirect_valid = 1'b0; trap_valid = 1'b0; mret_valid = 1'b0;
    halt_req = 1'b0; resume = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; pc_write = 1'b1; clear_req();
    redirect_pc = '0; trap_epc = '0;
    tick(); tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (if_valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_flags if_valid=%b halted=%b exp=0/0", if_valid, halted); end
    checks++; if (mepc !== 32'h0 || stall_cnt !== 32'h0 || misalign !== 1'b0) begin errors++; $display("FAIL reset_state mepc=%h cnt=%h mis=%b exp=0", mepc, stall_cnt, misalign); end
    rst = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL boot_cycle if_valid=%b pc=%h exp=0/0", if_valid, pc); end
    tick();
    checks++; if (if_valid !== 1'b1 || pc !== 32'h0) begin errors++; $display("FAIL first_fetch if_valid=%b pc=%h exp=1/0", if_valid, pc); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (pc !== 32'(i * 4)) begin errors++; $display("FAIL seq_fetch pc=%h exp=%h", pc, 32'(i * 4)); end
    end
  endtask

  task automatic test_stall_redirect();
    tick(); // 0xC -> 0x10
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL pre_stall pc=%h exp=%h", pc, 32'h10); end
    pc_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_hold pc=%h exp=%h", pc, 32'h10); end
    end
    checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL stall_flush got=%b exp=0", flush); end
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL redirect_flush got=%b exp=1", flush); end
    tick();
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL redirect_pc got=%h exp=%h", pc, 32'h40); end
    checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL redirect_no_stall got=%0d exp=3", stall_cnt); end
    clear_req(); pc_write = 1'b1;
  endtask

  task automatic test_trap_priority();
    trap_valid = 1'b1; trap_epc = 32'h24;
    redirect_valid = 1'b1; redirect_pc = 32'h80; mret_valid = 1'b1;
    tick();
    checks++; if (pc !== 32'h1000) begin errors++; $display("FAIL trap_pc got=%h exp=%h", pc, 32'h1000); end
    checks++; if (mepc !== 32'h24) begin errors++; $display("FAIL trap_mepc got=%h exp=%h", mepc, 32'h24); end
    clear_req(); mret_valid = 1'b1;
    tick();
    checks++; if (pc !== 32'h24) begin errors++; $display("FAIL mret_pc got=%h exp=%h", pc, 32'h24); end
    clear_req();
    tick();
    checks++; if (pc !== 32'h28) begin errors++; $display("FAIL after_mret pc=%h exp=%h", pc, 32'h28); end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick();
    checks++; if (pc !== 32'h1000 || mepc !== 32'h42) begin errors++; $display("FAIL misalign_trap pc=%h mepc=%h exp=1000/42", pc, mepc); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign_set got=%b exp=1", misalign); end
    redirect_pc = 32'h200;
    tick();
    checks++; if (pc !== 32'h200 || misalign !== 1'b1) begin errors++; $display("FAIL misalign_sticky pc=%h mis=%b exp=200/1", pc, misalign); end
    clear_req();
    tick();
    checks++; if (pc !== 32'h204 || mepc !== 32'h42) begin errors++; $display("FAIL post_misalign pc=%h mepc=%h exp=204/42", pc, mepc); end
  endtask

  task automatic test_halt_resume();
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    tick();
    clear_req(); halt_req = 1'b1;
    tick();
    checks++; if (pc !== 32'hC || halted !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL halt_enter pc=%h halted=%b if_valid=%b exp=c/1/0", pc, halted, if_valid); end
    clear_req();
    redirect_valid = 1'b1; redirect_pc = 32'h80; trap_valid = 1'b1; trap_epc = 32'h99; pc_write = 1'b0;
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL halt_flush got=%b exp=0", flush); end
    tick(); tick();
    checks++; if (pc !== 32'hC || mepc !== 32'h42 || stall_cnt !== 32'd3) begin errors++; $display("FAIL halt_hold pc=%h mepc=%h cnt=%0d exp=c/42/3", pc, mepc, stall_cnt); end
    checks++; if (halted !== 1'b1 || state_dbg !== 2'd2) begin errors++; $display("FAIL halt_stay halted=%b state=%0d exp=1/2", halted, state_dbg); end
    clear_req(); pc_write = 1'b1; halt_req = 1'b1; resume = 1'b1;
    tick();
    checks++; if (halted !== 1'b0 || if_valid !== 1'b1 || pc !== 32'hC) begin errors++; $display("FAIL resume halted=%b if_valid=%b pc=%h exp=0/1/c", halted, if_valid, pc); end
    clear_req();
    tick();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL resume_fetch pc=%h exp=%h", pc, 32'h10); end
  endtask

  task automatic test_wrap_saturate();
    rst8 = 1'b1; pc_write8 = 1'b1;
    redirect_valid8 = 1'b0; trap_valid8 = 1'b0; mret_valid8 = 1'b0;
    halt_req8 = 1'b0; resume8 = 1'b0; redirect_pc8 = '0; trap_epc8 = '0;
    tick();
    rst8 = 1'b0;
    tick(); // BOOT -> RUN, pc stays 0xF8
    checks++; if (pc8 !== 8'hF8 || if_valid8 !== 1'b1) begin errors++; $display("FAIL w8_boot pc=%h if_valid=%b exp=f8/1", pc8, if_valid8); end
    tick();
    checks++; if (pc8 !== 8'hFC) begin errors++; $display("FAIL w8_fc pc=%h exp=fc", pc8); end
    tick();
    checks++; if (pc8 !== 8'h00) begin errors++; $display("FAIL w8_wrap pc=%h exp=00", pc8); end
    pc_write8 = 1'b0;
    for (int i = 0; i < 254; i++) tick();
    checks++; if (stall_cnt8 !== 8'hFE) begin errors++; $display("FAIL w8_cnt_fe got=%h exp=fe", stall_cnt8); end
    for (int i = 0; i < 46; i++) tick();
    checks++; if (stall_cnt8 !== 8'hFF || pc8 !== 8'h00) begin errors++; $display("FAIL w8_saturate cnt=%h pc=%h exp=ff/00", stall_cnt8, pc8); end
  endtask

  task automatic test_async_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    #3;
    rst = 1'b1;
    #1;
    checks++; if (pc !== 32'h0 || if_valid !== 1'b0 || misalign !== 1'b0) begin errors++; $display("FAIL async_rst pc=%h if_valid=%b mis=%b exp=0/0/0", pc, if_valid, misalign); end
    checks++; if (mepc !== 32'h0 || stall_cnt !== 32'h0 || flush !== 1'b0) begin errors++; $display("FAIL async_rst_regs mepc=%h cnt=%h flush=%b exp=0", mepc, stall_cnt, flush); end
    clear_req();
    tick();
    rst = 1'b0;
    tick(); tick();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL rst_lost_redirect pc=%h exp=%h", pc, 32'h4); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst8 = 1'b1; pc_write8 = 1'b0;
    redirect_valid8 = 1'b0; trap_valid8 = 1'b0; mret_valid8 = 1'b0;
    halt_req8 = 1'b0; resume8 = 1'b0; redirect_pc8 = '0; trap_epc8 = '0;
    test_reset();
    test_stall_redirect();
    test_trap_priority();
    test_misalign();
    test_halt_resume();
    test_wrap_saturate();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
